// File: rtl/led_pattern_if.sv
// Control/status bundle for the LED pattern engine: the controller drives the
// master side, led_pattern sits on the slave side.
interface led_pattern_if #(
  parameter int unsigned LED_NUM  = 8,
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned PWM_BITS = 8
);

  logic                en;
  logic [1:0]          mode;
  logic [DIV_W-1:0]    div;
  logic                load;
  logic [LED_NUM-1:0]  pat_in;
  logic [PWM_BITS-1:0] duty;
  logic [LED_NUM-1:0]  pat_q;
  logic [LED_NUM-1:0]  led_sig;
  logic                step;

  modport master (
    output en, mode, div, load, pat_in, duty,
    input  pat_q, led_sig, step
  );

  modport slave (
    input  en, mode, div, load, pat_in, duty,
    output pat_q, led_sig, step
  );

endinterface

// File: rtl/led_pattern.sv
// Runtime-configurable LED pattern engine: rotate / bounce / blink at a programmable step rate.
// Optional global-brightness PWM stage on led_sig when LED_PWM_EN is defined.
module led_pattern #(
  parameter int unsigned        LED_NUM  = 8,
  parameter int unsigned        DIV_W    = 32,
  parameter logic [LED_NUM-1:0] INIT_STA = LED_NUM'(1),
  parameter int unsigned        PWM_BITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  led_pattern_if.slave  bus
);

  localparam int unsigned N = LED_NUM;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    MODE_ROR    = 2'd0,
    MODE_ROL    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic [DIV_W-1:0] r_cnt;
  logic [N-1:0]     r_pat;
  dir_e             r_dir;
  logic             r_step;

  logic [DIV_W-1:0] w_cnt_nxt;
  logic [N-1:0]     w_pat_nxt;
  dir_e             w_dir_nxt;
  logic             w_step_nxt;
  logic             w_due;
  logic [N-1:0]     w_pat_step;
  dir_e             w_dir_step;

  // Pattern and direction that a step would produce in the current mode
  always_comb begin : step_calc
    w_pat_step = r_pat;
    w_dir_step = r_dir;
    case (mode_e'(bus.mode))
      MODE_ROR: w_pat_step = {r_pat[0], r_pat[N-1:1]};
      MODE_ROL: w_pat_step = {r_pat[N-2:0], r_pat[N-1]};
      MODE_BOUNCE: begin
        // End bit for the current direction turns the pattern around
        if (r_dir == DIR_DOWN) begin
          if (r_pat[0]) begin
            w_dir_step = DIR_UP;
            w_pat_step = r_pat << 1;
          end else begin
            w_pat_step = r_pat >> 1;
          end
        end else begin
          if (r_pat[N-1]) begin
            w_dir_step = DIR_DOWN;
            w_pat_step = r_pat >> 1;
          end else begin
            w_pat_step = r_pat << 1;
          end
        end
      end
      default: w_pat_step = ~r_pat;
    endcase
  end

  // Divider and load/step arbitration; load wins over a due step
  always_comb begin : next_state
    w_cnt_nxt  = r_cnt;
    w_pat_nxt  = r_pat;
    w_dir_nxt  = r_dir;
    w_step_nxt = 1'b0;
    w_due      = bus.en && (r_cnt >= bus.div);
    if (bus.load) begin
      w_pat_nxt = bus.pat_in;
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_DOWN;
    end else if (bus.en) begin
      if (w_due) begin
        w_cnt_nxt  = '0;
        w_pat_nxt  = w_pat_step;
        w_dir_nxt  = w_dir_step;
        w_step_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      r_cnt  <= '0;
      r_pat  <= INIT_STA;
      r_dir  <= DIR_DOWN;
      r_step <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pat  <= w_pat_nxt;
      r_dir  <= w_dir_nxt;
      r_step <= w_step_nxt;
    end
  end

  assign bus.pat_q = r_pat;
  assign bus.step  = r_step;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [N-1:0]        r_led;

  // Free-running brightness counter gates the whole pattern
  always_ff @(posedge clk or negedge rst) begin : pwm_reg
    if (!rst) begin
      r_pwm_cnt <= '0;
      r_led     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_led     <= r_pat & {N{r_pwm_cnt < bus.duty}};
    end
  end

  assign bus.led_sig = r_led;
`else
  logic w_unused_duty;
  assign w_unused_duty = ^bus.duty;
  assign bus.led_sig   = r_pat;
`endif

endmodule
